mult_div_unit: RTL and testbench
================================

// Module: mult_div_unit
// PURPOSE
//  E-stage multiply/divide unit of the P7 pipeline. Owns the architectural HI/LO registers.
//  Executes mult/multu/div/divu as fixed-latency multicycle ops; serves mthi/mtlo/mfhi/mflo.
//  Drives busy and start to the hazard/stall unit, which stalls D-stage MDU instructions
//  while (busy | start). Sits beside the ALU; mdu_out joins the E-stage result mux.
// PARAMETERS
//  MULT_LAT  5   cycles busy stays high after a mult/multu start cycle (>=1)
//  DIV_LAT   10  cycles busy stays high after a div/divu start cycle (>=1)
// PORTS
//  clk      in   1   single clock, all state on rising edge
//  reset    in   1   asynchronous, active-high; clears all state
//  req      in   1   exception/interrupt flush this cycle; suppresses start and mthi/mtlo
//  mdu_op   in   4   0 NONE,1 MULT,2 MULTU,3 DIV,4 DIVU,5 MTHI,6 MTLO,7 MFHI,8 MFLO
//  rs_val   in   32  forwarded rs operand (dividend / multiplicand / mt source)
//  rt_val   in   32  forwarded rt operand (divisor / multiplier)
//  start    out  1   comb: mdu_op in {1..4} & !req & !busy
//  busy     out  1   registered: op in flight
//  hi       out  32  architectural HI
//  lo       out  32  architectural LO
//  mdu_out  out  32  comb: MFHI->hi, MFLO->lo, else 0
// BEHAVIOUR
//  Reset: hi=lo=0, busy=0, counter=0, state IDLE, pending result discarded.
//  FSM IDLE/BUSY.
//  IDLE:
//   - start=1 -> latch result into hi_tmp/lo_tmp, counter<=LAT, go BUSY.
//   - busy=1 from the next cycle for exactly LAT cycles.
//  BUSY:
//   - counter decrements each edge.
//   - at edge with counter==1: hi<=hi_tmp, lo<=lo_tmp, counter<=0, go IDLE.
//   - busy low on the following cycle; back-to-back start is allowed that cycle.
//   - new start in BUSY is ignored (start forced 0); stall unit guarantees none arrives.
//  MTHI/MTLO: when !req & !busy, write rs_val to hi/lo at edge; ignored while busy.
//  MFHI/MFLO read architectural hi/lo only, never hi_tmp/lo_tmp.
//  req rules:
//   - req in the start cycle -> op never begins, hi/lo unchanged.
//   - req while BUSY does not abort; the in-flight op completes and commits normally.
//  Arithmetic:
//   - MULT: signed 32x32->64, {hi,lo}=product.
//   - MULTU: same, unsigned.
//   - DIV: signed; lo=quotient truncated toward zero, hi=remainder with dividend's sign.
//   - DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
//   - DIVU: unsigned quotient/remainder.
//   - Divisor==0 (DIV/DIVU): full DIV_LAT busy, hi/lo keep prior values at commit.
//  Reset asserted mid-operation: immediate abort to IDLE, no commit.
//  hi/lo change only at commit, MTHI/MTLO, or reset.
// STRUCTURE
//  Shared package mdu_pkg: mdu_op encodings (MDU_NONE..MDU_MFLO), state encodings, default latencies.
//  mdu_pkg is also included by the decoder that generates mdu_op and by the stall unit.
//  One sub-module mdu_arith: combinational; inputs op/rs/rt, outputs 64-bit {hi_res,lo_res}
//  and a div_by_zero flag.
//  The top holds the FSM, counter, tmp registers and HI/LO.
// TESTING
//  1 MULT rs=0xFFFFFFFE(-2), rt=3 -> busy high 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
//  2 DIVU rs=100, rt=7 -> busy high 10 cycles, hi=2, lo=14; DIV rs=-7, rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
//  3 MULT with req=1 in start cycle -> start=0, busy never rises, hi/lo unchanged.
//    MTLO 0x1234 with req=1 -> lo unchanged.
//  4 Sequence:
//    - MTHI 0xAAAA -> hi=0xAAAA.
//    - DIV rs=5, rt=0 -> busy 10 cycles, hi=0xAAAA unchanged.
//    - MFHI -> mdu_out=0xAAAA.
//  5 MULTU 0xFFFFFFFF*0xFFFFFFFF; reset pulse at busy cycle 3 -> busy=0 immediately, hi=lo=0.
//    Next MULTU 2*3 -> lo=6 after 5 cycles.
//  6 Back-to-back: DIVU issued the cycle busy falls after a MULT -> accepted; MULT result committed first.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit, its decoder and the stall unit:
// mdu_op encodings, FSM state encodings and default latencies.
package mdu_pkg;

   typedef enum logic [3:0] {
      MDU_NONE  = 4'd0,
      MDU_MULT  = 4'd1,
      MDU_MULTU = 4'd2,
      MDU_DIV   = 4'd3,
      MDU_DIVU  = 4'd4,
      MDU_MTHI  = 4'd5,
      MDU_MTLO  = 4'd6,
      MDU_MFHI  = 4'd7,
      MDU_MFLO  = 4'd8
   } mdu_op_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } mdu_state_e;

   localparam int MULT_LAT_DEF = 5;
   localparam int DIV_LAT_DEF  = 10;

   function automatic logic is_arith_op(input logic [3:0] op);
      return (op == MDU_MULT) || (op == MDU_MULTU) || (op == MDU_DIV) || (op == MDU_DIVU);
   endfunction

   function automatic logic is_mult_op(input logic [3:0] op);
      return (op == MDU_MULT) || (op == MDU_MULTU);
   endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational multiply/divide datapath. res = {hi_res, lo_res}; div_by_zero flags a
// DIV/DIVU with a zero divisor so the caller can leave HI/LO untouched.
module mdu_arith
   import mdu_pkg::*;
(
   input  logic [3:0]  op,
   input  logic [31:0] rs,
   input  logic [31:0] rt,
   output logic [63:0] res,
   output logic        div_by_zero
);

   logic signed [63:0] rs_sx;
   logic signed [63:0] rt_sx;
   logic signed [31:0] rs_s;
   logic signed [31:0] rt_s;

   assign rs_sx = {{32{rs[31]}}, rs};
   assign rt_sx = {{32{rt[31]}}, rt};
   assign rs_s  = rs;
   assign rt_s  = rt;

   always_comb begin
      res         = '0;
      div_by_zero = 1'b0;
      case (op)
         MDU_MULT:  res = rs_sx * rt_sx;
         MDU_MULTU: res = {32'd0, rs} * {32'd0, rt};
         MDU_DIV: begin
            if (rt == 32'd0) begin
               div_by_zero = 1'b1;
            end else if (rs == 32'h8000_0000 && rt == 32'hFFFF_FFFF) begin
               // The only signed overflow case: quotient wraps to the dividend.
               res = {32'd0, 32'h8000_0000};
            end else begin
               res = {rs_s % rt_s, rs_s / rt_s};
            end
         end
         MDU_DIVU: begin
            if (rt == 32'd0) begin
               div_by_zero = 1'b1;
            end else begin
               res = {rs % rt, rs / rt};
            end
         end
         default: res = '0;
      endcase
   end

endmodule

// File: rtl/mult_div_unit.sv
// E-stage multiply/divide unit: fixed-latency IDLE/BUSY sequencer around mdu_arith,
// holding the architectural HI/LO registers and the pending result.
module mult_div_unit
   import mdu_pkg::*;
#(
   parameter int MULT_LAT = MULT_LAT_DEF,
   parameter int DIV_LAT  = DIV_LAT_DEF
)(
   input  logic        clk,
   input  logic        reset,
   input  logic        req,
   input  logic [3:0]  mdu_op,
   input  logic [31:0] rs_val,
   input  logic [31:0] rt_val,
   output logic        start,
   output logic        busy,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic [31:0] mdu_out
);

   localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
   localparam int CNT_W   = $clog2(MAX_LAT + 1);

   mdu_state_e         state_reg, state_next;
   logic [CNT_W-1:0]   counter_reg, counter_next;
   logic [31:0]        hi_reg, hi_next;
   logic [31:0]        lo_reg, lo_next;
   logic [31:0]        hi_tmp_reg, hi_tmp_next;
   logic [31:0]        lo_tmp_reg, lo_tmp_next;
   logic               dz_reg, dz_next;

   logic [63:0]        arith_res;
   logic               arith_dz;

   mdu_arith u_arith (
      .op          (mdu_op),
      .rs          (rs_val),
      .rt          (rt_val),
      .res         (arith_res),
      .div_by_zero (arith_dz)
   );

   assign busy  = (state_reg == ST_BUSY);
   assign start = is_arith_op(mdu_op) && !req && !busy;
   assign hi    = hi_reg;
   assign lo    = lo_reg;

   always_comb begin
      case (mdu_op)
         MDU_MFHI: mdu_out = hi_reg;
         MDU_MFLO: mdu_out = lo_reg;
         default:  mdu_out = '0;
      endcase
   end

   always_comb begin
      state_next   = state_reg;
      counter_next = counter_reg;
      hi_next      = hi_reg;
      lo_next      = lo_reg;
      hi_tmp_next  = hi_tmp_reg;
      lo_tmp_next  = lo_tmp_reg;
      dz_next      = dz_reg;
      case (state_reg)
         ST_IDLE: begin
            if (start) begin
               {hi_tmp_next, lo_tmp_next} = arith_res;
               dz_next      = arith_dz;
               counter_next = is_mult_op(mdu_op) ? CNT_W'(MULT_LAT) : CNT_W'(DIV_LAT);
               state_next   = ST_BUSY;
            end else if (!req) begin
               if (mdu_op == MDU_MTHI) hi_next = rs_val;
               if (mdu_op == MDU_MTLO) lo_next = rs_val;
            end
         end
         ST_BUSY: begin
            if (counter_reg == CNT_W'(1)) begin
               // A zero divisor still spends the full latency but leaves HI/LO alone.
               if (!dz_reg) begin
                  hi_next = hi_tmp_reg;
                  lo_next = lo_tmp_reg;
               end
               counter_next = '0;
               state_next   = ST_IDLE;
            end else begin
               counter_next = counter_reg - CNT_W'(1);
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg   <= ST_IDLE;
         counter_reg <= '0;
         hi_reg      <= '0;
         lo_reg      <= '0;
         hi_tmp_reg  <= '0;
         lo_tmp_reg  <= '0;
         dz_reg      <= 1'b0;
      end else begin
         state_reg   <= state_next;
         counter_reg <= counter_next;
         hi_reg      <= hi_next;
         lo_reg      <= lo_next;
         hi_tmp_reg  <= hi_tmp_next;
         lo_tmp_reg  <= lo_tmp_next;
         dz_reg      <= dz_next;
      end
   end

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: expected HI/LO and latency are queued at issue
// and compared when busy falls.
module tb_mult_div_unit;
   import mdu_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        req;
   logic [3:0]  mdu_op;
   logic [31:0] rs_val;
   logic [31:0] rt_val;
   logic        start;
   logic        busy;
   logic [31:0] hi;
   logic [31:0] lo;
   logic [31:0] mdu_out;

   always #5 clk = ~clk;

   mult_div_unit dut (
      .clk     (clk),
      .reset   (reset),
      .req     (req),
      .mdu_op  (mdu_op),
      .rs_val  (rs_val),
      .rt_val  (rt_val),
      .start   (start),
      .busy    (busy),
      .hi      (hi),
      .lo      (lo),
      .mdu_out (mdu_out)
   );

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      logic [31:0] old_hi;
      logic [31:0] old_lo;
      int          lat;
   } exp_t;

   exp_t        sb_q[$];
   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] m_hi     = '0;
   logic [31:0] m_lo     = '0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference arithmetic on 64-bit integers, updating the model HI/LO.
   function automatic void model_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      longint          sx = longint'($signed(a));
      longint          sy = longint'($signed(b));
      longint unsigned ux = {32'd0, a};
      longint unsigned uy = {32'd0, b};
      logic [63:0]     p;
      case (op)
         MDU_MULT:  begin p = 64'(sx * sy); m_hi = p[63:32]; m_lo = p[31:0]; end
         MDU_MULTU: begin p = ux * uy;      m_hi = p[63:32]; m_lo = p[31:0]; end
         MDU_DIV:   if (b != 0) begin m_lo = 32'(sx / sy); m_hi = 32'(sx % sy); end
         MDU_DIVU:  if (b != 0) begin m_lo = 32'(ux / uy); m_hi = 32'(ux % uy); end
         MDU_MTHI:  m_hi = a;
         MDU_MTLO:  m_lo = a;
         default:   ;
      endcase
   endfunction

   // Called and returns at a negedge; drives one op for one clock.
   task automatic issue(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic r);
      logic exp_start;
      exp_t e;
      mdu_op = op; rs_val = a; rt_val = b; req = r;
      exp_start = (op >= MDU_MULT) && (op <= MDU_DIVU) && !r && (sb_q.size() == 0);
      #1;
      check_eq({tag, ".start"}, start, exp_start);
      if (op == MDU_MFHI)      check_eq({tag, ".mdu_out"}, mdu_out, m_hi);
      else if (op == MDU_MFLO) check_eq({tag, ".mdu_out"}, mdu_out, m_lo);
      else                     check_eq({tag, ".mdu_out"}, mdu_out, 32'd0);
      if (exp_start) begin
         e.old_hi = m_hi; e.old_lo = m_lo;
         model_op(op, a, b);
         e.hi = m_hi; e.lo = m_lo;
         e.lat = is_mult_op(op) ? 5 : 10;
         sb_q.push_back(e);
      end else if ((op == MDU_MTHI || op == MDU_MTLO) && !r && sb_q.size() == 0) begin
         model_op(op, a, b);
      end
      $display("issue %s op=%0d rs=0x%0h rt=0x%0h req=%0b start=%0b", tag, op, a, b, r, start);
      @(negedge clk);
      mdu_op = MDU_NONE; req = 1'b0; rs_val = '0; rt_val = '0;
      if (sb_q.size() != 0) begin
         check_eq({tag, ".busy"}, busy, 1'b1);
         check_eq({tag, ".hi_hold"}, hi, sb_q[0].old_hi);
         check_eq({tag, ".lo_hold"}, lo, sb_q[0].old_lo);
      end else begin
         check_eq({tag, ".busy"}, busy, 1'b0);
         check_eq({tag, ".hi"}, hi, m_hi);
         check_eq({tag, ".lo"}, lo, m_lo);
      end
   endtask

   // Counts remaining busy cycles (skip already spent), then pops and compares.
   task automatic wait_commit(input string tag, input int skip);
      int   cnt = skip;
      exp_t e;
      while (busy === 1'b1 && cnt < 100) begin
         cnt++;
         @(negedge clk);
      end
      if (sb_q.size() == 0) begin
         check_eq({tag, ".sb_empty"}, 64'd1, 64'd0);
      end else begin
         e = sb_q.pop_front();
         check_eq({tag, ".lat"}, 64'(cnt), 64'(e.lat));
         check_eq({tag, ".hi"}, hi, e.hi);
         check_eq({tag, ".lo"}, lo, e.lo);
         $display("commit %s busy_cycles=%0d hi=0x%0h lo=0x%0h", tag, cnt, hi, lo);
      end
   endtask

   initial begin
      reset = 1'b1; req = 1'b0; mdu_op = MDU_NONE; rs_val = '0; rt_val = '0;
      @(negedge clk);
      @(negedge clk);
      check_eq("rst.busy", busy, 1'b0);
      check_eq("rst.hi", hi, 32'd0);
      check_eq("rst.lo", lo, 32'd0);
      reset = 1'b0;
      @(negedge clk);

      // Directed cases
      issue("mult_m2x3", MDU_MULT, 32'hFFFF_FFFE, 32'd3, 1'b0);
      wait_commit("mult_m2x3", 0);
      check_eq("mult_m2x3.hi_const", hi, 32'hFFFF_FFFF);
      check_eq("mult_m2x3.lo_const", lo, 32'hFFFF_FFFA);

      issue("divu_100_7", MDU_DIVU, 32'd100, 32'd7, 1'b0);
      wait_commit("divu_100_7", 0);
      check_eq("divu_100_7.lo_const", lo, 32'd14);
      check_eq("divu_100_7.hi_const", hi, 32'd2);

      issue("div_m7_2", MDU_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
      wait_commit("div_m7_2", 0);
      check_eq("div_m7_2.lo_const", lo, 32'hFFFF_FFFD);
      check_eq("div_m7_2.hi_const", hi, 32'hFFFF_FFFF);

      issue("mult_req", MDU_MULT, 32'd9, 32'd9, 1'b1);
      @(negedge clk);
      check_eq("mult_req.busy_later", busy, 1'b0);
      issue("mtlo_req", MDU_MTLO, 32'h1234, 32'd0, 1'b1);

      issue("mthi", MDU_MTHI, 32'hAAAA, 32'd0, 1'b0);
      check_eq("mthi.hi_const", hi, 32'hAAAA);
      issue("div_by0", MDU_DIV, 32'd5, 32'd0, 1'b0);
      wait_commit("div_by0", 0);
      check_eq("div_by0.hi_const", hi, 32'hAAAA);
      issue("mfhi", MDU_MFHI, 32'd0, 32'd0, 1'b0);
      issue("mflo", MDU_MFLO, 32'd0, 32'd0, 1'b0);

      // Reset during busy cycle 3
      issue("multu_ff", MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      #1;
      check_eq("midrst.busy", busy, 1'b0);
      check_eq("midrst.hi", hi, 32'd0);
      check_eq("midrst.lo", lo, 32'd0);
      sb_q.delete();
      m_hi = '0; m_lo = '0;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check_eq("postrst.busy", busy, 1'b0);
      issue("multu_2x3", MDU_MULTU, 32'd2, 32'd3, 1'b0);
      wait_commit("multu_2x3", 0);
      check_eq("multu_2x3.lo_const", lo, 32'd6);

      // Back-to-back: DIVU issued on the cycle busy falls
      issue("b2b_mult", MDU_MULT, 32'd7, 32'hFFFF_FFF7, 1'b0);
      wait_commit("b2b_mult", 0);
      issue("b2b_divu", MDU_DIVU, 32'd1000, 32'd33, 1'b0);
      wait_commit("b2b_divu", 0);

      // MTHI and req while busy: ignored, no abort
      issue("busy_mult", MDU_MULT, 32'd123456, 32'd789, 1'b0);
      issue("busy_mthi", MDU_MTHI, 32'h5555, 32'd0, 1'b0);
      issue("busy_req", MDU_MULT, 32'd1, 32'd1, 1'b1);
      wait_commit("busy_mult", 2);

      issue("div_ovf", MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
      wait_commit("div_ovf", 0);
      check_eq("div_ovf.lo_const", lo, 32'h8000_0000);
      check_eq("div_ovf.hi_const", hi, 32'd0);

      // Random arithmetic ops, occasional zero divisor
      for (int i = 0; i < 8; i++) begin
         logic [3:0]  op;
         logic [31:0] a, b;
         op = 4'($urandom_range(1, 4));
         a  = $urandom();
         b  = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom();
         issue($sformatf("rnd%0d", i), op, a, b, 1'b0);
         wait_commit($sformatf("rnd%0d", i), 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
